sparsity_bank_mem: RTL and testbench
====================================

Name: sparsity_bank_mem

Overview:
- Parametrised banked sparsity-index memory for the FlexML datapath; successor to the fixed 2×1024×32 sparsity store.
- One external write port (loader/DMA) and one read port (PE array sparsity fetch), N_BANKS single-port banks selected by the upper address bits.
- Adds a write handshake with stall, same-bank conflict arbitration with a starvation guard, write-to-read forwarding, and a redundant-read skip for power.

Parameters:
- DATA_W, 32, word width.
- BANK_DEPTH, 1024, words per bank; power of 2.
- N_BANKS, 2, bank count; power of 2, ≥2.
- WR_STARVE_MAX, 4, consecutive blocked cycles allowed for a pending write before it wins arbitration.
- Derived: BA_W = log2(BANK_DEPTH), BS_W = log2(N_BANKS), ADDR_W = BA_W + BS_W.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- scan_en_in  in  1  scan mode; forces all bank enables inactive.
- cfg_sparsity  in  16  read enable config; reads are legal only when nonzero.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid&&wr_ready.
- wr_addr  in  ADDR_W  write address; [ADDR_W-1:BA_W] is the bank.
- wr_data  in  DATA_W  write data.
- rd_valid  in  1  read request.
- rd_ready  out  1  read accepted when rd_valid&&rd_ready.
- rd_addr  in  ADDR_W  read address.
- rd_rsp_valid  out  1  read data valid; 1-cycle pulse.
- rd_rsp_data  out  DATA_W  read data; holds its last value between responses.

Behaviour:
- Reset values: wr_ready=1, rd_rsp_valid=0, rd_rsp_data=0. Write pending register, starvation counter, last-read-valid flag and stats counters are all cleared. Bank contents are not reset.
- Banks: each bank is a single-port sync SRAM, one access per cycle, read data at cycle+1.
- Write stage: an accepted write is captured into a pending register (wp_valid, wp_addr, wp_data). It commits to its bank on the first cycle it wins arbitration.
  - wr_ready = !wp_valid || commit_this_cycle.
  - Back-to-back writes at 1/cycle are possible when no conflict occurs.
- Read acceptance: rd_ready = (cfg_sparsity!=0) && !scan_en_in && !force_write.
  - Accepted read at cycle N gives rd_rsp_valid=1 and data at N+1.
  - If cfg_sparsity==0, no read is accepted; rd_rsp_data holds its value.
- Arbitration, when a pending write and an accepted read target the same bank:
  - The read wins; the write stays pending and the starve counter increments.
  - When the counter reaches WR_STARVE_MAX, force_write=1 for one cycle: rd_ready=0, the write commits, and the counter clears.
  - The counter also clears on any write commit.
  - Different banks: both proceed in the same cycle.
- Forwarding: if a read is accepted whose full address equals wp_addr while wp_valid, the response data is wp_data (captured at N), not the bank contents.
- Redundant-read skip: the block keeps last_rd_addr and last_valid.
  - If an accepted read equals last_rd_addr, last_valid=1, and it is not forwarded: the bank is not enabled, and rd_rsp_valid pulses at N+1 with the held data.
  - Any write commit to last_rd_addr clears last_valid.
  - A forwarded read sets last_valid=0.
- scan_en_in=1: no bank enables, rd_ready=0, pending write held, wr_ready=!wp_valid.
- Reset mid-operation: the pending write is dropped (not committed); any in-flight response is dropped.

Optional Feature:
- Macro: SPARSITY_MEM_STATS_EN.
- Defined: adds outputs stat_rd_cnt, stat_wr_cnt, stat_conflict_cnt (16 bits each, saturating at 0xFFFF, reset 0).
  - stat_rd_cnt counts accepted reads.
  - stat_wr_cnt counts committed writes.
  - stat_conflict_cnt counts cycles a pending write lost arbitration.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Write 0xDEADBEEF to addr 0x005 and 0xCAFEF00D to 0x405; read 0x005 then 0x405, cfg_sparsity=1 -> responses 0xDEADBEEF then 0xCAFEF00D, each 1 cycle after acceptance.
- Pending write to 0x010 with continuous reads to bank 0 (0x020) -> wr_ready low; after 4 blocked cycles rd_ready=0 for 1 cycle and the write commits; stat_conflict_cnt=4.
- Write 0x12345678 to 0x033, read 0x033 the cycle after acceptance -> response 0x12345678 via forwarding, and bank 0 is later verified updated.
- Read 0x100 twice consecutively -> second read has the bank enable inactive, response equals the first. Then write 0x100 = 0x1 and read again -> bank enabled, response 0x1.
- cfg_sparsity=0 with rd_valid=1 -> rd_ready=0, no rd_rsp_valid. scan_en_in=1 with wr_valid -> write held, no bank access, wr_ready=0 after the first capture.
- Assert reset with a write pending -> wr_ready=1, rd_rsp_valid=0, and the pending data is never written (read-back of that address shows the old value).

Source files
------------

// File: rtl/sparsity_bank_mem_if.sv
// Write/read handshake bus for sparsity_bank_mem.
// The loader/PE side drives it as master; the memory is the slave.
interface sparsity_bank_mem_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rsp_valid;
  logic [DATA_W-1:0] rd_rsp_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    input  wr_ready, rd_ready, rd_rsp_valid, rd_rsp_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    output wr_ready, rd_ready, rd_rsp_valid, rd_rsp_data
  );
endinterface

// File: rtl/sparsity_bank_mem.sv
// Banked sparsity-index memory: pending-write stage, read-priority bank arbitration with a
// starvation guard, write-to-read forwarding and redundant-read skip. Stats: SPARSITY_MEM_STATS_EN.
module sparsity_bank_mem #(
  parameter int DATA_W        = 32,
  parameter int BANK_DEPTH    = 1024,
  parameter int N_BANKS       = 2,
  parameter int WR_STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               scan_en_in,
  input  logic [15:0]        cfg_sparsity,
  sparsity_bank_mem_if.slave bus
`ifdef SPARSITY_MEM_STATS_EN
  ,
  output logic [15:0]        stat_rd_cnt,
  output logic [15:0]        stat_wr_cnt,
  output logic [15:0]        stat_conflict_cnt
`endif
);
  localparam int BA_W   = $clog2(BANK_DEPTH);
  localparam int BS_W   = $clog2(N_BANKS);
  localparam int ADDR_W = BA_W + BS_W;
  localparam int CNT_W  = (WR_STARVE_MAX > 0) ? $clog2(WR_STARVE_MAX + 1) : 1;

  typedef logic [BS_W-1:0]   bank_t;
  typedef logic [ADDR_W-1:0] addr_t;

  logic              wp_valid;
  addr_t             wp_addr;
  logic [DATA_W-1:0] wp_data;
  logic [CNT_W-1:0]  starve_cnt;
  addr_t             last_rd_addr;
  logic              last_valid;
  logic              rsp_src_bank;
  bank_t             rsp_bank;
  logic [DATA_W-1:0] rsp_hold;
  logic [DATA_W-1:0] bank_q [N_BANKS];
  logic [N_BANKS-1:0] bank_rd_en;
  logic [N_BANKS-1:0] bank_wr_en;

  bank_t wp_bank, rd_bank;
  logic  force_write, rd_acc, wr_acc, conflict, commit, rd_fwd, rd_skip, rd_from_bank;

  assign wp_bank = wp_addr[ADDR_W-1:BA_W];
  assign rd_bank = bus.rd_addr[ADDR_W-1:BA_W];

  assign force_write  = wp_valid && (starve_cnt == CNT_W'(WR_STARVE_MAX));
  assign bus.rd_ready = (cfg_sparsity != 16'd0) && !scan_en_in && !force_write;
  assign rd_acc       = bus.rd_valid && bus.rd_ready;
  // A same-bank read always beats the write, even if it would be served without the bank.
  assign conflict     = wp_valid && rd_acc && (rd_bank == wp_bank);
  assign commit       = wp_valid && !scan_en_in && !conflict;
  assign bus.wr_ready = !wp_valid || commit;
  assign wr_acc       = bus.wr_valid && bus.wr_ready;

  assign rd_fwd       = rd_acc && wp_valid && (bus.rd_addr == wp_addr);
  assign rd_skip      = rd_acc && !rd_fwd && last_valid && (bus.rd_addr == last_rd_addr);
  assign rd_from_bank = rd_acc && !rd_fwd && !rd_skip;

  assign bus.rd_rsp_data = rsp_src_bank ? bank_q[rsp_bank] : rsp_hold;

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [BANK_DEPTH];
    logic [DATA_W-1:0] q;

    assign bank_wr_en[b] = !scan_en_in && commit && (wp_bank == bank_t'(b));
    assign bank_rd_en[b] = !scan_en_in && rd_from_bank && (rd_bank == bank_t'(b));
    assign bank_q[b]     = q;

    // NOTE: SRAM array and its output latch carry no reset; clearing them would turn the
    // macro into flops, and nothing may observe them before a write/read fills them.
    always_ff @(posedge clk) begin
      if (bank_wr_en[b])      mem[wp_addr[BA_W-1:0]] <= wp_data;
      else if (bank_rd_en[b]) q <= mem[bus.rd_addr[BA_W-1:0]];
    end
  end

  // NOTE: every register here uses <= so all state updates see the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_valid         <= 1'b0;
      wp_addr          <= '0;
      wp_data          <= '0;
      starve_cnt       <= '0;
      last_rd_addr     <= '0;
      last_valid       <= 1'b0;
      rsp_src_bank     <= 1'b0;
      rsp_bank         <= '0;
      rsp_hold         <= '0;
      bus.rd_rsp_valid <= 1'b0;
    end else begin
      if (wr_acc) begin
        wp_valid <= 1'b1;
        wp_addr  <= bus.wr_addr;
        wp_data  <= bus.wr_data;
      end else if (commit) begin
        wp_valid <= 1'b0;
      end

      if (commit)        starve_cnt <= '0;
      else if (conflict) starve_cnt <= starve_cnt + 1'b1;

      if (rd_acc) begin
        last_rd_addr <= bus.rd_addr;
        last_valid   <= !rd_fwd;
      end else if (commit && (wp_addr == last_rd_addr)) begin
        last_valid <= 1'b0;
      end

      // The hold register tracks the visible output so it survives later bank activity.
      bus.rd_rsp_valid <= rd_acc;
      if (rd_fwd) begin
        rsp_src_bank <= 1'b0;
        rsp_hold     <= wp_data;
      end else if (rd_from_bank) begin
        rsp_src_bank <= 1'b1;
        rsp_bank     <= rd_bank;
      end else begin
        rsp_src_bank <= 1'b0;
        rsp_hold     <= bus.rd_rsp_data;
      end
    end
  end

`ifdef SPARSITY_MEM_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_rd_cnt       <= '0;
      stat_wr_cnt       <= '0;
      stat_conflict_cnt <= '0;
    end else begin
      if (rd_acc && (stat_rd_cnt != 16'hFFFF))         stat_rd_cnt       <= stat_rd_cnt + 1'b1;
      if (commit && (stat_wr_cnt != 16'hFFFF))         stat_wr_cnt       <= stat_wr_cnt + 1'b1;
      if (conflict && (stat_conflict_cnt != 16'hFFFF)) stat_conflict_cnt <= stat_conflict_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_sparsity_bank_mem.sv
// Directed + randomized bench for sparsity_bank_mem; the reference model is the map of the
// latest accepted write per address (a read sees writes accepted in earlier cycles only).
module tb_sparsity_bank_mem;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 11;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        scan_en_in = 1'b0;
  logic [15:0] cfg_sparsity = 16'd1;

  always #5 clk = ~clk;

  sparsity_bank_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef SPARSITY_MEM_STATS_EN
  logic [15:0] stat_rd_cnt, stat_wr_cnt, stat_conflict_cnt;
`endif

  sparsity_bank_mem #(
    .DATA_W(DATA_W), .BANK_DEPTH(1024), .N_BANKS(2), .WR_STARVE_MAX(STARVE)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .scan_en_in       (scan_en_in),
    .cfg_sparsity     (cfg_sparsity),
    .bus              (bus)
`ifdef SPARSITY_MEM_STATS_EN
    ,
    .stat_rd_cnt      (stat_rd_cnt),
    .stat_wr_cnt      (stat_wr_cnt),
    .stat_conflict_cnt(stat_conflict_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] model [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] last_rsp = '0;
  logic [ADDR_W-1:0] pool [9] = '{11'h005, 11'h405, 11'h020, 11'h010, 11'h033,
                                  11'h100, 11'h0FF, 11'h406, 11'h7FF};

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    check(tag, 32'(obs), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int waited = 0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    #1;
    while (!bus.wr_ready && waited < 20) begin
      tick();
      waited++;
    end
    check_b("wr_accept", bus.wr_ready, 1'b1);
    model[a] = d;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  // exp_en < 0 skips the bank-enable check.
  task automatic do_read(input string tag, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] exp, input int exp_en);
    int waited = 0;
    bus.rd_valid = 1'b1;
    bus.rd_addr  = a;
    #1;
    while (!bus.rd_ready && waited < 20) begin
      tick();
      waited++;
    end
    check_b({tag, "_accept"}, bus.rd_ready, 1'b1);
    if (exp_en >= 0) check_b({tag, "_bank_en"}, |dut.bank_rd_en, exp_en[0]);
    tick();
    bus.rd_valid = 1'b0;
    check_b({tag, "_vld"}, bus.rd_rsp_valid, 1'b1);
    check({tag, "_data"}, bus.rd_rsp_data, exp);
    last_rsp = exp;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rd_acc, wr_acc, exp_vld;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_valid = 1'b0; bus.rd_addr = '0;

    // Reset state.
    repeat (3) tick();
    check_b("rst_wr_ready", bus.wr_ready, 1'b1);
    check_b("rst_rsp_vld", bus.rd_rsp_valid, 1'b0);
    check("rst_rsp_data", bus.rd_rsp_data, 32'h0);
    reset = 1'b1;
    tick();

    // Fill the address pool, then two-bank readback.
    do_write(11'h005, 32'hDEADBEEF);
    do_write(11'h405, 32'hCAFEF00D);
    do_write(11'h020, 32'h20202020);
    do_write(11'h010, 32'h10101010);
    do_write(11'h033, 32'h33333333);
    do_write(11'h100, 32'hABCD0100);
    do_write(11'h0FF, 32'h0F0F0F0F);
    do_write(11'h406, 32'h04060406);
    do_write(11'h7FF, 32'h77777777);
    tick();
    do_read("rd_005", 11'h005, 32'hDEADBEEF, 1);
    do_read("rd_405", 11'h405, 32'hCAFEF00D, 1);
    tick();
    check_b("rsp_pulse", bus.rd_rsp_valid, 1'b0);

    // Starvation: pending write to 0x010 against continuous reads of 0x020.
    bus.wr_valid = 1'b1; bus.wr_addr = 11'h010; bus.wr_data = 32'hA5A50010;
    bus.rd_valid = 1'b1; bus.rd_addr = 11'h020;
    #1;
    check_b("st_wr_ready0", bus.wr_ready, 1'b1);
    check_b("st_rd_ready0", bus.rd_ready, 1'b1);
    model[11'h010] = 32'hA5A50010;
    tick();
    bus.wr_valid = 1'b0;
    for (int i = 0; i < STARVE; i++) begin
      check_b("st_wr_stall", bus.wr_ready, 1'b0);
      check_b("st_rd_wins", bus.rd_ready, 1'b1);
      check("st_rsp_data", bus.rd_rsp_data, 32'h20202020);
      tick();
    end
    check_b("st_force_rd_ready", bus.rd_ready, 1'b0);
    check_b("st_force_wr_ready", bus.wr_ready, 1'b1);
    check_b("st_force_commit", |dut.bank_wr_en, 1'b1);
    tick();
    check_b("st_rd_ready_back", bus.rd_ready, 1'b1);
    check_b("st_no_rsp", bus.rd_rsp_valid, 1'b0);
`ifdef SPARSITY_MEM_STATS_EN
    check("stat_conflict", 32'(stat_conflict_cnt), 32'd4);
`endif
    bus.rd_valid = 1'b0;
    tick();
    do_read("rd_010", 11'h010, 32'hA5A50010, 1);

    // Forwarding from the pending register, then bank readback.
    do_write(11'h033, 32'h12345678);
    do_read("fwd_033", 11'h033, 32'h12345678, 0);
    tick();
    do_read("bank_033", 11'h033, 32'h12345678, 1);

    // Redundant-read skip, invalidated by a write.
    do_read("skip_a", 11'h100, 32'hABCD0100, 1);
    do_read("skip_b", 11'h100, 32'hABCD0100, 0);
    do_write(11'h100, 32'h00000001);
    tick();
    do_read("skip_c", 11'h100, 32'h00000001, 1);

    // cfg_sparsity == 0 blocks reads; response data holds.
    cfg_sparsity = 16'd0;
    bus.rd_valid = 1'b1; bus.rd_addr = 11'h005;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_b("cfg0_rd_ready", bus.rd_ready, 1'b0);
      tick();
      check_b("cfg0_no_rsp", bus.rd_rsp_valid, 1'b0);
      check("cfg0_hold", bus.rd_rsp_data, last_rsp);
    end
    cfg_sparsity = 16'd1;
    bus.rd_valid = 1'b0;

    // Scan mode: write captured but held, no bank access.
    scan_en_in = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_addr = 11'h406; bus.wr_data = 32'h5CA1AB1E;
    bus.rd_valid = 1'b1; bus.rd_addr = 11'h005;
    #1;
    check_b("scan_capture", bus.wr_ready, 1'b1);
    check_b("scan_rd_ready", bus.rd_ready, 1'b0);
    model[11'h406] = 32'h5CA1AB1E;
    tick();
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_b("scan_wr_held", bus.wr_ready, 1'b0);
      check_b("scan_no_wr_en", |dut.bank_wr_en, 1'b0);
      check_b("scan_no_rd_en", |dut.bank_rd_en, 1'b0);
      check_b("scan_no_rsp", bus.rd_rsp_valid, 1'b0);
      tick();
    end
    scan_en_in = 1'b0;
    bus.rd_valid = 1'b0;
    #1;
    check_b("scan_release_commit", |dut.bank_wr_en, 1'b1);
    tick();
    do_read("rd_406", 11'h406, 32'h5CA1AB1E, 1);

    // Reset with a pending write and a response in flight.
    bus.wr_valid = 1'b1; bus.wr_addr = 11'h0FF; bus.wr_data = 32'hBAD0BAD0;
    bus.rd_valid = 1'b1; bus.rd_addr = 11'h020;
    tick();
    bus.wr_valid = 1'b0;
    tick();
    check_b("mid_pending", bus.wr_ready, 1'b0);
    check_b("mid_inflight", bus.rd_rsp_valid, 1'b1);
    reset = 1'b0;
    #1;
    check_b("mid_rst_wr_ready", bus.wr_ready, 1'b1);
    check_b("mid_rst_rsp_vld", bus.rd_rsp_valid, 1'b0);
    check("mid_rst_rsp_data", bus.rd_rsp_data, 32'h0);
`ifdef SPARSITY_MEM_STATS_EN
    check("stat_rd_rst", 32'(stat_rd_cnt), 32'd0);
    check("stat_wr_rst", 32'(stat_wr_cnt), 32'd0);
    check("stat_cf_rst", 32'(stat_conflict_cnt), 32'd0);
`endif
    bus.rd_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    do_read("rd_0ff", 11'h0FF, 32'h0F0F0F0F, 1);

    // Randomized traffic against the latest-accepted-write model.
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.wr_valid = ($urandom_range(0, 2) != 0);
      bus.wr_addr  = pool[$urandom_range(0, 8)];
      bus.wr_data  = $urandom();
      bus.rd_valid = ($urandom_range(0, 3) != 0);
      bus.rd_addr  = pool[$urandom_range(0, 8)];
      cfg_sparsity = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      scan_en_in   = ($urandom_range(0, 15) == 0);
      #1;
      if (cfg_sparsity == 16'd0 || scan_en_in) check_b("rnd_rd_blocked", bus.rd_ready, 1'b0);
      rd_acc = bus.rd_valid && bus.rd_ready;
      wr_acc = bus.wr_valid && bus.wr_ready;
      exp_vld = rd_acc;
      if (rd_acc) last_rsp = model[bus.rd_addr];
      if (wr_acc) model[bus.wr_addr] = bus.wr_data;
      tick();
      check_b("rnd_rsp_vld", bus.rd_rsp_valid, exp_vld);
      check("rnd_rsp_data", bus.rd_rsp_data, last_rsp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
